// File: rtl/ex_issue_ctrl.sv
// ============================================================================
//  Module      : ex_issue_ctrl
//  Description : Issue controller feeding the execute-stage preprocessor.
//                Queues decoded instructions and issues them one per cycle,
//                stalling on MEM_READ until mem_rdy or a timeout. Optional
//                issue counter enabled by macro EX_ISSUE_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [6:0]  instr_control,
    input  logic [31:0] instr_src1,
    input  logic [31:0] instr_src2,
    input  logic [31:0] instr_imm,
    input  logic        flush,
    input  logic        mem_rdy,
    output logic        enable_ex,
    output logic [6:0]  control_out,
    output logic [31:0] src1_out,
    output logic [31:0] src2_out,
    output logic [31:0] imm_out,
    output logic        busy,
    output logic        mem_timeout,
    output logic [15:0] issue_count
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_TMO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam int c_ENTRY_W = 7 + 3 * 32;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ISSUE    = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;

    localparam logic [2:0] c_OPSEL_MEM_READ = 3'b101;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [1:0]           r_state;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 r_enable_ex;
    logic                 r_mem_timeout;
    logic [6:0]           r_control_out;
    logic [31:0]          r_src1_out;
    logic [31:0]          r_src2_out;
    logic [31:0]          r_imm_out;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_wait_expire;
    logic [1:0]           w_next_state;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_full        = (r_count == c_CNT_W'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_push        = instr_valid & ~w_full;
    assign w_head        = r_mem[r_rd_ptr];
    // Timeout fires on the edge that closes the MEM_TIMEOUT-th idle wait cycle
    assign w_wait_expire = (r_tmo_cnt == c_TMO_W'(MEM_TIMEOUT - 1)) & ~mem_rdy;

    always_comb begin
        w_pop        = 1'b0;
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (r_control_out[6:4] == c_OPSEL_MEM_READ) begin
                    w_next_state = c_ST_MEM_WAIT;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_MEM_WAIT: begin
                if (mem_rdy || w_wait_expire) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = c_ST_ISSUE;
                    end else begin
                        w_next_state = c_ST_IDLE;
                    end
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Storage has no reset; occupancy and pointers define validity
    always_ff @(posedge clock) begin
        if (!reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= {instr_control, instr_src1, instr_src2, instr_imm};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_state       <= c_ST_IDLE;
            r_tmo_cnt     <= '0;
            r_enable_ex   <= 1'b0;
            r_mem_timeout <= 1'b0;
            r_control_out <= '0;
            r_src1_out    <= '0;
            r_src2_out    <= '0;
            r_imm_out     <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= c_ST_IDLE;
            r_tmo_cnt   <= '0;
            r_enable_ex <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + c_PTR_W'(1);
                r_control_out <= w_head[c_ENTRY_W-1 -: 7];
                r_src1_out    <= w_head[95:64];
                r_src2_out    <= w_head[63:32];
                r_imm_out     <= w_head[31:0];
            end
            r_count     <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            r_state     <= w_next_state;
            r_enable_ex <= w_pop;
            if (r_state == c_ST_MEM_WAIT && w_next_state == c_ST_MEM_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (r_state == c_ST_MEM_WAIT && w_wait_expire) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

`ifdef EX_ISSUE_PERF_EN
    logic [15:0] r_issue_count;

    // Counts alongside the enable_ex strobe it produces; flush leaves it intact
    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_count <= '0;
        end else if (!flush && w_pop) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    assign issue_count = r_issue_count;
`else
    assign issue_count = 16'h0000;
`endif

    assign instr_ready = ~w_full;
    assign enable_ex   = r_enable_ex;
    assign control_out = r_control_out;
    assign src1_out    = r_src1_out;
    assign src2_out    = r_src2_out;
    assign imm_out     = r_imm_out;
    assign mem_timeout = r_mem_timeout;
    assign busy        = ~w_empty | (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_ctrl.sv
// ============================================================================
//  Module      : tb_ex_issue_ctrl
//  Description : Directed self-checking bench for ex_issue_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_issue_ctrl;

    localparam logic [6:0] c_ADD = 7'b001_0_000;
    localparam logic [6:0] c_RD  = 7'b101_1_000;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [6:0]  instr_control;
    logic [31:0] instr_src1;
    logic [31:0] instr_src2;
    logic [31:0] instr_imm;
    logic        flush;
    logic        mem_rdy;
    logic        enable_ex;
    logic [6:0]  control_out;
    logic [31:0] src1_out;
    logic [31:0] src2_out;
    logic [31:0] imm_out;
    logic        busy;
    logic        mem_timeout;
    logic [15:0] issue_count;

    int n_checks = 0;
    int n_pass   = 0;

    ex_issue_ctrl #(.DEPTH(4), .MEM_TIMEOUT(15)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_control (instr_control),
        .instr_src1    (instr_src1),
        .instr_src2    (instr_src2),
        .instr_imm     (instr_imm),
        .flush         (flush),
        .mem_rdy       (mem_rdy),
        .enable_ex     (enable_ex),
        .control_out   (control_out),
        .src1_out      (src1_out),
        .src2_out      (src2_out),
        .imm_out       (imm_out),
        .busy          (busy),
        .mem_timeout   (mem_timeout),
        .issue_count   (issue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [6:0] c, input logic [31:0] imm);
        instr_valid   = v;
        instr_control = c;
        instr_src1    = 32'd5;
        instr_src2    = 32'd7;
        instr_imm     = imm;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        mem_rdy = 1'b0;
        drive(1'b0, 7'd0, 32'd0);
        tick();
        tick();
        chk("rst_en", 32'(enable_ex), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tmo", 32'(mem_timeout), 32'd0);
        chk("rst_ctrl", 32'(control_out), 32'd0);
        chk("rst_src1", src1_out, 32'd0);
        chk("rst_imm", imm_out, 32'd0);
        chk("rst_cnt", 32'(issue_count), 32'd0);
        reset = 1'b0;

        // Four back-to-back ADDs
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, c_ADD, 32'(i));
            tick();
            chk("add_en", 32'(enable_ex), (i >= 1) ? 32'd1 : 32'd0);
            if (i >= 1) chk("add_imm", imm_out, 32'(i - 1));
        end
        drive(1'b0, c_ADD, 32'd0);
        tick();
        chk("add_en_last", 32'(enable_ex), 32'd1);
        chk("add_imm_last", imm_out, 32'd3);
        chk("add_src1", src1_out, 32'd5);
        chk("add_src2", src2_out, 32'd7);
        chk("add_ctrl", 32'(control_out), 32'(c_ADD));
        chk("add_busy1", 32'(busy), 32'd1);
        tick();
        chk("add_en_off", 32'(enable_ex), 32'd0);
        tick();
        chk("add_busy0", 32'(busy), 32'd0);
        chk("add_hold", imm_out, 32'd3);

        // MEM_READ stall while the queue fills
        drive(1'b1, c_RD, 32'd100);
        tick();
        chk("rd_en0", 32'(enable_ex), 32'd0);
        drive(1'b1, c_ADD, 32'd101);
        tick();
        chk("rd_issue", 32'(enable_ex), 32'd1);
        chk("rd_ctrl", 32'(control_out), 32'(c_RD));
        chk("rd_imm", imm_out, 32'd100);
        drive(1'b1, c_ADD, 32'd102);
        tick();
        chk("rd_wait1", 32'(enable_ex), 32'd0);
        drive(1'b1, c_ADD, 32'd103);
        tick();
        chk("rd_wait2", 32'(enable_ex), 32'd0);
        drive(1'b1, c_ADD, 32'd104);
        tick();
        chk("full_ready", 32'(instr_ready), 32'd0);
        chk("full_en", 32'(enable_ex), 32'd0);
        drive(1'b1, c_ADD, 32'd99);
        mem_rdy = 1'b1;
        tick();
        chk("rdy_issue", 32'(enable_ex), 32'd1);
        chk("rdy_imm", imm_out, 32'd101);
        chk("rdy_ready", 32'(instr_ready), 32'd1);
        drive(1'b0, c_ADD, 32'd0);
        mem_rdy = 1'b0;
        tick();
        chk("drain_102", imm_out, 32'd102);
        tick();
        chk("drain_103", imm_out, 32'd103);
        tick();
        chk("drain_104", imm_out, 32'd104);
        chk("drain_en", 32'(enable_ex), 32'd1);
        tick();
        chk("drain_off", 32'(enable_ex), 32'd0);
        chk("drain_no99", imm_out, 32'd104);
        tick();
        chk("drain_busy", 32'(busy), 32'd0);

        // MEM_READ timeout
        drive(1'b1, c_RD, 32'd50);
        tick();
        drive(1'b1, c_ADD, 32'd51);
        tick();
        chk("tmo_rd_issue", imm_out, 32'd50);
        drive(1'b0, c_ADD, 32'd0);
        tick();
        repeat (14) tick();
        chk("tmo_pre_flag", 32'(mem_timeout), 32'd0);
        chk("tmo_pre_en", 32'(enable_ex), 32'd0);
        tick();
        chk("tmo_flag", 32'(mem_timeout), 32'd1);
        chk("tmo_next_en", 32'(enable_ex), 32'd1);
        chk("tmo_next_imm", imm_out, 32'd51);
        tick();
        chk("tmo_off", 32'(enable_ex), 32'd0);
        chk("tmo_sticky", 32'(mem_timeout), 32'd1);

        // Flush with a concurrent push
        drive(1'b1, c_RD, 32'd60);
        tick();
        drive(1'b1, c_ADD, 32'd61);
        tick();
        drive(1'b1, c_ADD, 32'd62);
        tick();
        drive(1'b1, c_ADD, 32'd63);
        tick();
        chk("fl_pre_busy", 32'(busy), 32'd1);
        drive(1'b1, c_ADD, 32'd77);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, c_ADD, 32'd0);
        chk("fl_en", 32'(enable_ex), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_ready", 32'(instr_ready), 32'd1);
        chk("fl_tmo_kept", 32'(mem_timeout), 32'd1);
        tick();
        chk("fl_dropped_en", 32'(enable_ex), 32'd0);
        tick();
        chk("fl_dropped_en2", 32'(enable_ex), 32'd0);
        chk("fl_busy2", 32'(busy), 32'd0);

        // Reset during MEM_WAIT
        drive(1'b1, c_RD, 32'd80);
        tick();
        drive(1'b1, c_ADD, 32'd81);
        tick();
        drive(1'b0, c_ADD, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_en", 32'(enable_ex), 32'd0);
        chk("mrst_ctrl", 32'(control_out), 32'd0);
        chk("mrst_src1", src1_out, 32'd0);
        chk("mrst_src2", src2_out, 32'd0);
        chk("mrst_imm", imm_out, 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(instr_ready), 32'd1);
        chk("mrst_tmo", 32'(mem_timeout), 32'd0);
        chk("mrst_cnt", 32'(issue_count), 32'd0);
        drive(1'b1, c_ADD, 32'd90);
        tick();
        drive(1'b0, c_ADD, 32'd0);
        tick();
        chk("mrst_issue_en", 32'(enable_ex), 32'd1);
        chk("mrst_issue_imm", imm_out, 32'd90);

        // Nine more issues: ten since the last reset
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, c_ADD, 32'(200 + i));
            tick();
        end
        drive(1'b0, c_ADD, 32'd0);
        repeat (4) tick();
        chk("perf_last_imm", imm_out, 32'd208);
        chk("perf_busy", 32'(busy), 32'd0);
`ifdef EX_ISSUE_PERF_EN
        chk("perf_count", 32'(issue_count), 32'd10);
`else
        chk("perf_count", 32'(issue_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
